// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared state encoding and default halt/bubble instruction words
package run_monitor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2, TIMEOUT = 2'd3} state_t;
    localparam logic [31:0] JAL_SELF = 32'h0000006F;
    localparam logic [31:0] NOP_BUBBLE = 32'h00000000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones and flags increments lost to saturation
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         ovf
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            value <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            value <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&value) ovf <= 1'b1;
            else value <= value + W'(1);
        end
endmodule

// File: rtl/run_monitor.sv
// run_monitor: detects the fetch/decode self-loop halt pattern and counts run cycles and events
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int                 INSTR_W      = 32,
    parameter int                 CNT_W        = 32,
    parameter int                 NUM_EVT      = 4,
    parameter logic [INSTR_W-1:0] HALT_INSTR   = INSTR_W'(JAL_SELF),
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(NOP_BUBBLE),
    parameter int                 HALT_CONFIRM = 1,
    parameter int                 TIMEOUT_CYC  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic [INSTR_W-1:0]       fetch_instr,
    input  logic [INSTR_W-1:0]       decode_instr,
    input  logic [NUM_EVT-1:0]       evt,
    output logic [1:0]               state,
    output logic                     halted,
    output logic                     timeout,
    output logic [CNT_W-1:0]         cycles,
    output logic [NUM_EVT*CNT_W-1:0] evt_count,
    output logic [NUM_EVT-1:0]       evt_ovf
);
    localparam int CW = $clog2(HALT_CONFIRM + 1);
    state_t st;
    logic [CW-1:0] confirm;
    logic run, match, hit, tmo, cyc_ovf_unused;
    assign run = (st == RUN) && !clear && !start;
    assign match = (fetch_instr == HALT_INSTR) && (decode_instr == BUBBLE_INSTR);
    assign hit = match && (confirm == CW'(HALT_CONFIRM - 1));
    assign tmo = (TIMEOUT_CYC != 0) && (cycles == CNT_W'(TIMEOUT_CYC - 1));
    assign state = st;
    assign halted = st == HALTED;
    assign timeout = st == TIMEOUT;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st <= IDLE;
            confirm <= '0;
        end else if (clear) begin
            st <= IDLE;
            confirm <= '0;
        end else if (start) begin
            st <= RUN;
            confirm <= '0;
        end else if (run) begin
            st <= hit ? HALTED : tmo ? TIMEOUT : RUN;
            confirm <= match ? confirm + CW'(1) : '0;
        end
    // the halting edge is not a counted run cycle; the timeout edge is
    sat_counter #(.W(CNT_W)) u_cyc (
        .clk(clk), .rst(rst), .clr(clear | start), .inc(run && !hit),
        .value(cycles), .ovf(cyc_ovf_unused)
    );
    for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
        sat_counter #(.W(CNT_W)) u_evt (
            .clk(clk), .rst(rst), .clr(clear | start), .inc(run && evt[k]),
            .value(evt_count[k*CNT_W +: CNT_W]), .ovf(evt_ovf[k])
        );
    end
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: three differently configured monitors on shared random stimulus vs a behavioural model
module tb_run_monitor;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, clear = 1'b0, chk_en = 1'b0;
    logic [31:0] fetch = '0, decode = '0;
    logic [3:0] evt = '0;
    logic [1:0] s0, s1, s2;
    logic h0, h1, h2, t0, t1, t2;
    logic [31:0] c0, c1;
    logic [3:0] c2;
    logic [127:0] e0, e1;
    logic [15:0] e2;
    logic [3:0] o0, o1, o2;
    int checks = 0, passes = 0;
    always #5 clk = ~clk;
    run_monitor u0 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .fetch_instr(fetch), .decode_instr(decode),
        .evt(evt), .state(s0), .halted(h0), .timeout(t0), .cycles(c0), .evt_count(e0), .evt_ovf(o0)
    );
    run_monitor #(.HALT_CONFIRM(3), .TIMEOUT_CYC(100)) u1 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .fetch_instr(fetch), .decode_instr(decode),
        .evt(evt), .state(s1), .halted(h1), .timeout(t1), .cycles(c1), .evt_count(e1), .evt_ovf(o1)
    );
    run_monitor #(.CNT_W(4), .HALT_CONFIRM(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .fetch_instr(fetch), .decode_instr(decode),
        .evt(evt), .state(s2), .halted(h2), .timeout(t2), .cycles(c2), .evt_count(e2), .evt_ovf(o2)
    );
    int hc[3] = '{1, 3, 2};
    int to[3] = '{0, 100, 0};
    int cw[3] = '{32, 32, 4};
    longint mx[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    int m_st[3];
    longint m_cyc[3];
    int m_conf[3];
    longint m_evt[3][4];
    bit m_ovf[3][4];
    bit mt, ht;
    task automatic m_zero(input int i);
        m_cyc[i] = 0;
        m_conf[i] = 0;
        for (int k = 0; k < 4; k++) begin
            m_evt[i][k] = 0;
            m_ovf[i][k] = 0;
        end
    endtask
    // model: 0 idle, 1 run, 2 halted, 3 timeout
    always @(posedge clk or negedge rst)
        for (int i = 0; i < 3; i++) begin
            if (!rst || clear) begin
                m_st[i] = 0;
                m_zero(i);
            end else if (start) begin
                m_st[i] = 1;
                m_zero(i);
            end else if (m_st[i] == 1) begin
                mt = (fetch == 32'h6F) && (decode == 32'h0);
                ht = mt && (m_conf[i] == hc[i] - 1);
                for (int k = 0; k < 4; k++)
                    if (evt[k]) begin
                        if (m_evt[i][k] == mx[i]) m_ovf[i][k] = 1;
                        else m_evt[i][k]++;
                    end
                if (ht) m_st[i] = 2;
                else begin
                    if (to[i] != 0 && m_cyc[i] == to[i] - 1) m_st[i] = 3;
                    if (m_cyc[i] < mx[i]) m_cyc[i]++;
                    m_conf[i] = mt ? m_conf[i] + 1 : 0;
                end
            end
        end
    task automatic chk(input int i, input logic [1:0] st, input logic h, input logic t,
                       input logic [63:0] cy, input logic [127:0] ec, input logic [3:0] ov);
        logic [127:0] xe;
        logic [3:0] xo;
        xe = '0;
        for (int k = 0; k < 4; k++) begin
            xe |= 128'(m_evt[i][k]) << (k * cw[i]);
            xo[k] = m_ovf[i][k];
        end
        checks++;
        if (st === 2'(m_st[i]) && h === (m_st[i] == 2) && t === (m_st[i] == 3) &&
            cy === 64'(m_cyc[i]) && ec === xe && ov === xo) passes++;
        else $display("FAIL model dut%0d t=%0t state=%0d want %0d halted=%b timeout=%b cycles=%0d want %0d evt_count=%h want %h evt_ovf=%b want %b",
                      i, $time, st, m_st[i], h, t, cy, m_cyc[i], ec, xe, ov, xo);
    endtask
    always @(negedge clk)
        if (chk_en) begin
            chk(0, s0, h0, t0, 64'(c0), e0, o0);
            chk(1, s1, h1, t1, 64'(c1), e1, o1);
            chk(2, s2, h2, t2, 64'(c2), 128'(e2), o2);
        end
    task automatic lit(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s got %0h expected %0h", n, a, e);
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic nm();
        fetch = $urandom;
        if (fetch == 32'h6F) fetch = 32'h13;
        decode = $urandom;
        evt = 4'($urandom);
    endtask
    task automatic pat();
        fetch = 32'h6F;
        decode = 32'h0;
        evt = 4'($urandom);
    endtask
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    initial begin
        nm();
        start = 1'($urandom);
        clear = 1'($urandom);
        repeat (3) tick();
        start = 1'b0;
        clear = 1'b0;
        rst = 1'b1;
        chk_en = 1'b1;
        tick();
        lit("reset_state", 128'(s0), 0);
        lit("reset_cycles", 128'(c0), 0);
        lit("reset_evt_count", e0, 0);
        lit("reset_halted", 128'(h0), 0);
        pat();
        repeat (3) tick();
        lit("idle_ignores_pattern", 128'(s1), 0);
        pat();
        go();
        for (int i = 0; i < 20; i++) begin
            nm();
            tick();
        end
        pat();
        tick();
        lit("halt20_halted", 128'(h0), 1);
        lit("halt20_cycles", 128'(c0), 20);
        for (int i = 0; i < 50; i++) begin
            fetch = $urandom_range(0, 1) ? 32'h6F : $urandom;
            decode = $urandom_range(0, 1) ? 32'h0 : $urandom;
            evt = 4'($urandom);
            tick();
        end
        lit("halt20_hold_halted", 128'(h0), 1);
        lit("halt20_hold_cycles", 128'(c0), 20);
        go();
        for (int i = 0; i < 5; i++) begin
            nm();
            tick();
        end
        pat(); tick();
        pat(); tick();
        nm(); tick();
        pat(); tick();
        pat(); tick();
        lit("confirm3_not_yet", 128'(h1), 0);
        pat(); tick();
        lit("confirm3_halted", 128'(h1), 1);
        lit("confirm3_cycles", 128'(c1), 10);
        go();
        for (int i = 0; i < 30; i++) begin
            fetch = 32'h6F;
            decode = 32'h13;
            evt = 4'($urandom);
            tick();
        end
        lit("nonbubble_u0_run", 128'(s0), 1);
        lit("nonbubble_u1_run", 128'(s1), 1);
        lit("nonbubble_cycles", 128'(c0), 30);
        go();
        for (int i = 0; i < 100; i++) begin
            nm();
            tick();
        end
        lit("timeout_flag", 128'(t1), 1);
        lit("timeout_cycles", 128'(c1), 100);
        go();
        for (int i = 1; i <= 100; i++) begin
            if (i >= 98) pat();
            else nm();
            tick();
        end
        lit("halt_at_100_halted", 128'(h1), 1);
        lit("halt_at_100_timeout", 128'(t1), 0);
        lit("halt_at_100_cycles", 128'(c1), 99);
        go();
        for (int i = 0; i < 20; i++) begin
            nm();
            evt = 4'b0001;
            tick();
        end
        lit("sat_count0", 128'(e2[3:0]), 15);
        lit("sat_ovf0", 128'(o2[0]), 1);
        lit("sat_others", 128'({e2[15:4], o2[3:1]}), 0);
        go();
        lit("sat_restart_count", 128'(e2), 0);
        lit("sat_restart_ovf", 128'(o2), 0);
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        lit("start_clear_idle", 128'({s0, s1, s2}), 0);
        go();
        for (int i = 0; i < 5; i++) begin
            nm();
            tick();
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        lit("async_rst_state", 128'({s0, s1}), 0);
        lit("async_rst_cycles", 128'(c0), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 60) == 0;
            clear = ($urandom % 300) == 0;
            fetch = ($urandom % 3 != 0) ? 32'h6F : $urandom;
            decode = ($urandom % 3 != 0) ? 32'h0 : (($urandom % 2 != 0) ? 32'h13 : $urandom);
            evt = 4'($urandom);
            tick();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable end-of-program and performance monitor that watches the fetch and decode instruction words of the core inside soc.
- Detects the self-loop halt pattern, which is a configurable halt word in fetch while decode holds a bubble.
- Reports elapsed run cycles, per-event counts and a timeout.
- Replaces ad-hoc cycle counting in testbenches; benches read its outputs directly.

Parameters:
- INSTR_W, 32, width of instruction words.
- CNT_W, 32, width of cycle and event counters.
- NUM_EVT, 4, number of independent event counters.
- HALT_INSTR, 32'h0000006F, fetch word that signals halt (jal x0,0).
- BUBBLE_INSTR, 32'h00000000, decode word that must coincide with HALT_INSTR.
- HALT_CONFIRM, 1, consecutive matching cycles required to declare halt (>=1).
- TIMEOUT_CYC, 0, cycle count that forces TIMEOUT; 0 disables.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin/restart a run (pulse).
- clear  in  1  synchronous return to IDLE and zero all counters.
- fetch_instr  in  INSTR_W  instruction leaving fetch.
- decode_instr  in  INSTR_W  instruction in decode.
- evt  in  NUM_EVT  per-cycle event strobes (retire, stall, flush, ...).
- state  out  2  current FSM state.
- halted  out  1  high while state==HALTED.
- timeout  out  1  high while state==TIMEOUT.
- cycles  out  CNT_W  run cycle count.
- evt_count  out  NUM_EVT*CNT_W  counter k at bits [k*CNT_W +: CNT_W].
- evt_ovf  out  NUM_EVT  sticky saturation flag per event counter.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - cycles, evt_count, evt_ovf and the confirm counter are 0.
  - halted=0, timeout=0.
- States: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3. Outputs are registered; halted and timeout are decoded from the state register.
- match = (fetch_instr==HALT_INSTR) && (decode_instr==BUBBLE_INSTR).
- hit = match && (confirm==HALT_CONFIRM-1).
- Transitions, evaluated at each rising edge, priority top-down:
  - clear=1: state to IDLE; all counters, confirm and evt_ovf to 0. Applies in any state.
  - start=1 in any state: state to RUN; cycles, evt_count, evt_ovf and confirm to 0. A restart mid-RUN is legal.
  - RUN with hit: state to HALTED. cycles is NOT incremented on this edge. evt_count IS incremented for active strobes.
  - RUN with TIMEOUT_CYC!=0 and cycles==TIMEOUT_CYC-1 and no hit: cycles to TIMEOUT_CYC, state to TIMEOUT. Halt wins over timeout on the same edge.
  - RUN otherwise:
    - cycles+1, saturating at all-ones.
    - confirm = match ? confirm+1 : 0.
    - evt_count[k]+1 for each evt[k]=1.
  - HALTED/TIMEOUT: hold all values until start or clear.
  - IDLE: hold.
- Reported halt cycle count: with HALT_CONFIRM=1, a pattern seen on the first RUN cycle gives cycles=0. A pattern first seen N cycles after entering RUN gives cycles=N+HALT_CONFIRM-1.
- Saturation:
  - Counters stop at 2^CNT_W-1 with no wrap.
  - evt_ovf[k] sets when evt[k]=1 while evt_count[k] is already saturated; it clears only on start, clear or reset.
- Inputs are ignored outside RUN. A match seen in IDLE does not preload confirm.
- Reset asserted mid-run forces IDLE immediately, without waiting for a clock edge.

Decomposition:
- Package run_monitor_pkg holds:
  - enum state_t {IDLE, RUN, HALTED, TIMEOUT};
  - constant JAL_SELF=32'h0000006F;
  - constant NOP_BUBBLE=32'h00000000.
- Sub-module sat_counter #(W) with ports clk, rst, clr, inc, value, ovf.
- Instantiate sat_counter NUM_EVT times for the event counters and once for cycles (ovf unused).

Test Plan:
- Reset with all inputs random, then rst released -> state=0, cycles=0, evt_count=0, halted=0.
- start pulse, 20 non-matching cycles, then fetch=0x6F with decode=0 (HALT_CONFIRM=1) -> halted=1 on the next edge, cycles=20, values held for 50 further cycles.
- HALT_CONFIRM=3: pattern for 2 cycles, broken for 1 cycle, then held for 3 cycles -> halt only after the third consecutive match. fetch=0x6F with decode=0x13 never halts.
- TIMEOUT_CYC=100 with no pattern -> timeout=1 with cycles=100. With the pattern arriving exactly on edge 100 -> halted=1, timeout=0.
- CNT_W=4 with evt[0] constantly high for 20 cycles -> evt_count[0]=15, evt_ovf[0]=1, other counters 0. A following start clears evt_count and evt_ovf.
- start and clear in the same cycle -> IDLE. rst pulsed low mid-RUN between edges -> state=IDLE and cycles=0 before the next edge.
